// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the MM:SS BCD countdown timer: state encodings and digit moduli.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned DIGIT_WIDTH      = 4;
  localparam int unsigned SEC_ONES_MOD_DEF = 10;
  localparam int unsigned SEC_TENS_MOD_DEF = 6;
  localparam int unsigned MIN_ONES_MOD_DEF = 10;
  localparam int unsigned MIN_TENS_MOD_DEF = 10;

endpackage

// File: rtl/countdown_timer_counter_down_digit.sv
// One BCD down-counting digit; borrows out when decremented from zero and reloads MOD-1.
module counter_down_digit #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             borrow_out,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MOD - 1);

  assign borrow_out = en && (out == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (load) begin
      out <= load_val;
    end else if (en) begin
      if (out == '0) out <= TOP_VAL;
      else           out <= out - WIDTH'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: preset load with clamping, run/pause FSM, borrow-chained digits, expiry flags.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH        = DIGIT_WIDTH,
  parameter int unsigned SEC_ONES_MOD = SEC_ONES_MOD_DEF,
  parameter int unsigned SEC_TENS_MOD = SEC_TENS_MOD_DEF,
  parameter int unsigned MIN_ONES_MOD = MIN_ONES_MOD_DEF,
  parameter int unsigned MIN_TENS_MOD = MIN_TENS_MOD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               load,
  input  logic               start,
  input  logic               pause,
  input  logic [4*WIDTH-1:0] preset,
  output logic [4*WIDTH-1:0] out,
  output logic               running,
  output logic               done,
  output logic               expired
);

  state_t state, state_nxt;

  logic [WIDTH-1:0] so_q, st_q, mo_q, mt_q;
  logic [WIDTH-1:0] so_ld, st_ld, mo_ld, mt_ld;
  logic             b0, b1, b2, b3;
  logic             dec_en, out_zero, last_sec;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v, input int unsigned mod);
    return (32'(v) >= mod) ? WIDTH'(mod - 1) : v;
  endfunction

  assign mt_ld = clamp(preset[4*WIDTH-1:3*WIDTH], MIN_TENS_MOD);
  assign mo_ld = clamp(preset[3*WIDTH-1:2*WIDTH], MIN_ONES_MOD);
  assign st_ld = clamp(preset[2*WIDTH-1:WIDTH],   SEC_TENS_MOD);
  assign so_ld = clamp(preset[WIDTH-1:0],         SEC_ONES_MOD);

  assign out      = {mt_q, mo_q, st_q, so_q};
  assign out_zero = (out == '0);
  assign last_sec = (mt_q == '0) && (mo_q == '0) && (st_q == '0) && (so_q == WIDTH'(1));

  // Load and pause both outrank a coincident tick, so they gate the borrow-in.
  assign dec_en = tick && (state == ST_RUN) && !pause && !load;

  counter_down_digit #(.WIDTH(WIDTH), .MOD(SEC_ONES_MOD)) u_sec_ones (
    .clk(clk), .rst(rst), .load(load), .load_val(so_ld),
    .en(dec_en), .borrow_out(b0), .out(so_q)
  );

  counter_down_digit #(.WIDTH(WIDTH), .MOD(SEC_TENS_MOD)) u_sec_tens (
    .clk(clk), .rst(rst), .load(load), .load_val(st_ld),
    .en(b0), .borrow_out(b1), .out(st_q)
  );

  counter_down_digit #(.WIDTH(WIDTH), .MOD(MIN_ONES_MOD)) u_min_ones (
    .clk(clk), .rst(rst), .load(load), .load_val(mo_ld),
    .en(b1), .borrow_out(b2), .out(mo_q)
  );

  counter_down_digit #(.WIDTH(WIDTH), .MOD(MIN_TENS_MOD)) u_min_tens (
    .clk(clk), .rst(rst), .load(load), .load_val(mt_ld),
    .en(b2), .borrow_out(b3), .out(mt_q)
  );

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_PAUSED: if (start) state_nxt = out_zero ? ST_DONE : ST_RUN;
        ST_RUN: begin
          if (pause)                  state_nxt = ST_PAUSED;
          else if (tick && last_sec)  state_nxt = ST_DONE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      done    <= (state_nxt == ST_DONE);
      expired <= (state_nxt == ST_DONE) && (state != ST_DONE);
    end
  end

  logic unused_borrow;
  assign unused_borrow = b3;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: directed scenarios plus random commands against a seconds-count reference model.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        rst, tick, load, start, pause;
  logic [15:0] preset;
  logic [15:0] out;
  logic        running, done, expired;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining time in whole seconds plus a plain state number.
  int m_secs = 0;
  int m_st   = 0;  // 0 idle, 1 run, 2 paused, 3 done
  bit m_exp  = 1'b0;

  countdown_timer dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .start(start), .pause(pause),
    .preset(preset), .out(out), .running(running), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] secs_to_bcd(input int s);
    int mins, secs;
    logic [15:0] r;
    mins = s / 60;
    secs = s % 60;
    r[15:12] = 4'(mins / 10);
    r[11:8]  = 4'(mins % 10);
    r[7:4]   = 4'(secs / 10);
    r[3:0]   = 4'(secs % 10);
    return r;
  endfunction

  function automatic int preset_to_secs(input logic [15:0] p);
    int mt, mo, st, so;
    mt = (int'(p[15:12]) > 9) ? 9 : int'(p[15:12]);
    mo = (int'(p[11:8])  > 9) ? 9 : int'(p[11:8]);
    st = (int'(p[7:4])   > 5) ? 5 : int'(p[7:4]);
    so = (int'(p[3:0])   > 9) ? 9 : int'(p[3:0]);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  task automatic model_edge();
    m_exp = 1'b0;
    if (rst) begin
      m_secs = 0;
      m_st   = 0;
    end else if (load) begin
      m_secs = preset_to_secs(preset);
      m_st   = 0;
    end else if (m_st == 0 || m_st == 2) begin
      if (start) begin
        if (m_secs != 0) m_st = 1;
        else begin m_st = 3; m_exp = 1'b1; end
      end
    end else if (m_st == 1) begin
      if (pause) m_st = 2;
      else if (tick) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin m_st = 3; m_exp = 1'b1; end
      end
    end
  endtask

  task automatic step(input bit r, input bit t, input bit l, input bit s, input bit p,
                      input logic [15:0] pv);
    @(negedge clk);
    rst = r; tick = t; load = l; start = s; pause = p; preset = pv;
    @(posedge clk);
    model_edge();
    #1;
    check("out",     32'(out),     32'(secs_to_bcd(m_secs)));
    check("running", 32'(running), 32'(m_st == 1));
    check("done",    32'(done),    32'(m_st == 3));
    check("expired", 32'(expired), 32'(m_exp));
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 16'h0000);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; preset = '0;
    step(1, 0, 0, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 0, 16'h0000);
    check("reset_out", 32'(out), 32'h0);

    // Reset mid-RUN
    step(0, 0, 1, 0, 0, 16'h0230);
    step(0, 0, 0, 1, 0, 16'h0000);
    ticks(3);
    step(1, 1, 0, 0, 0, 16'h0000);
    step(1, 1, 0, 0, 0, 16'h0000);
    check("rst_mid_out", 32'(out), 32'h0);
    check("rst_mid_run", 32'(running), 32'h0);
    idle_cyc(1);

    // Borrow chain across all digits
    step(0, 0, 1, 0, 0, 16'h1000);
    step(0, 0, 0, 1, 0, 16'h0000);
    ticks(1);
    check("borrow_0959", 32'(out), 32'h0959);
    ticks(1);
    check("borrow_0958", 32'(out), 32'h0958);

    // Expiry and hold at 00:00
    step(0, 0, 1, 0, 0, 16'h0002);
    step(0, 0, 0, 1, 0, 16'h0000);
    ticks(2);
    check("expiry_pulse", 32'(expired), 32'h1);
    ticks(3);
    check("expiry_hold", 32'(out), 32'h0);
    step(0, 0, 0, 1, 0, 16'h0000);
    check("done_start_ignored", 32'(done), 32'h1);

    // Pause / resume
    step(0, 0, 1, 0, 0, 16'h0130);
    step(0, 0, 0, 1, 0, 16'h0000);
    ticks(3);
    check("pr_0127", 32'(out), 32'h0127);
    step(0, 0, 0, 0, 1, 16'h0000);
    ticks(5);
    check("pr_paused", 32'(out), 32'h0127);
    step(0, 0, 0, 1, 0, 16'h0000);
    ticks(1);
    check("pr_0126", 32'(out), 32'h0126);

    // Collisions and clamping
    step(0, 1, 0, 0, 1, 16'h0000);
    check("tick_pause", 32'(out), 32'h0126);
    step(0, 0, 0, 1, 0, 16'h0000);
    step(0, 1, 0, 1, 1, 16'h0000);
    check("tick_pause_start", 32'(running), 32'h0);
    step(0, 0, 0, 1, 0, 16'h0000);
    step(0, 1, 1, 0, 0, 16'h0345);
    check("tick_load", 32'(out), 32'h0345);
    step(0, 0, 1, 0, 0, 16'h9F7A);
    check("clamp", 32'(out), 32'h9959);

    // Zero start
    step(0, 0, 1, 0, 0, 16'h0000);
    step(0, 0, 0, 1, 0, 16'h0000);
    check("zero_start_exp", 32'(expired), 32'h1);
    step(0, 0, 1, 0, 0, 16'h0005);
    check("zero_reload_done", 32'(done), 32'h0);

    // Random command mix
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] pv;
      bit r, t, l, s, p;
      pv = 16'($urandom);
      if ($urandom_range(0, 3) != 0) pv = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom)};
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 29) == 0);
      s = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 24) == 0);
      t = ($urandom_range(0, 1) == 0);
      step(r, t, l, s, p, pv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
